// File: rtl/key_debounce_n_if.sv
// Key debouncer signal bundle: raw pins in, debounced level and event pulses out.
// master = control side driving the pins in simulation, slave = the debouncer.
interface key_debounce_n_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key;
    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] long_pulse;

    modport master (
        output key,
        input  level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );

    modport slave (
        input  key,
        output level,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );
endinterface

// File: rtl/key_debounce_n.sv
// Multi-key debouncer: 2-flop sync, shared sample tick, N-sample stability filter, event pulses.
// Optional long-press detection is built only when KEY_LONGPRESS_EN is defined.
module key_debounce_n #(
    parameter int NUM_KEYS     = 4,
    parameter int TICK_DIV     = 20000,
    parameter int STABLE_TICKS = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int LONG_TICKS   = 100
) (
    input  logic           clk,
    input  logic           n_reset,
    key_debounce_n_if.slave bus
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS) + 1;

    localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0]       CNT_LAST  = CW'(STABLE_TICKS - 1);
    localparam logic [NUM_KEYS-1:0] KEY_REL   = (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}}
                                                                  : {NUM_KEYS{1'b0}};

    if (NUM_KEYS < 1 || TICK_DIV < 2 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_param_check
        $error("key_debounce_n: parameter out of range");
    end

    logic [TW-1:0]       r_tick_cnt;
    logic                w_tick;
    logic [NUM_KEYS-1:0] r_sync_a;
    logic [NUM_KEYS-1:0] r_sync_b;
    logic [NUM_KEYS-1:0] w_sample;
    logic [NUM_KEYS-1:0] w_toggle;
    logic [NUM_KEYS-1:0] r_level;
    logic [NUM_KEYS-1:0] r_press;
    logic [NUM_KEYS-1:0] r_release;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Sync flops reset to the released pin level so reset release looks like "no key pressed".
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync_a <= KEY_REL;
            r_sync_b <= KEY_REL;
        end else begin
            r_sync_a <= bus.key;
            r_sync_b <= r_sync_a;
        end
    end

    assign w_sample = (ACTIVE_LOW != 0) ? ~r_sync_b : r_sync_b;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_filter
        logic [CW-1:0] r_cnt;
        logic          w_diff;
        logic          w_done;

        assign w_diff      = w_sample[g] ^ r_level[g];
        assign w_done      = w_tick & w_diff & (r_cnt == CNT_LAST);
        assign w_toggle[g] = w_done;

        // A single agreeing sample restarts the run, so bounces never accumulate.
        always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                if (!w_diff || w_done) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_level   <= r_level ^ w_toggle;
            r_press   <= w_toggle & ~r_level;
            r_release <= w_toggle & r_level;
        end
    end

    assign bus.level         = r_level;
    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;

`ifdef KEY_LONGPRESS_EN
    localparam int            LW        = $clog2(LONG_TICKS) + 1;
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS - 1);
    localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_TICKS);

    logic [NUM_KEYS-1:0] w_long_hit;
    logic [NUM_KEYS-1:0] r_long;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_long
        logic [LW-1:0] r_long_cnt;

        // The release edge itself must not fire, even when it lands on the final tick.
        assign w_long_hit[g] = w_tick & r_level[g] & ~w_toggle[g] & (r_long_cnt == LONG_LAST);

        always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
                r_long_cnt <= '0;
            end else if (!r_level[g] || w_toggle[g]) begin
                r_long_cnt <= '0;
            end else if (w_tick && (r_long_cnt != LONG_SAT)) begin
                r_long_cnt <= r_long_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_long <= '0;
        end else begin
            r_long <= w_long_hit;
        end
    end

    assign bus.long_pulse = r_long;
`else
    assign bus.long_pulse = '0;
`endif

endmodule
